// File: rtl/round_sat_stream.sv
// round_sat_stream: multi-channel streaming rounder/saturator with runtime precision and rounding mode
module round_sat_stream #(
  parameter int NCH       = 4,
  parameter int W_IN_MAX  = 19,
  parameter int W_OUT     = 16,
  parameter bit IS_SIGNED = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NCH*W_IN_MAX-1:0] s_data,
  input  logic [7:0]              s_prec,
  input  logic [1:0]              s_mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NCH*W_OUT-1:0]    m_data,
  output logic [NCH-1:0]          m_sat,
  input  logic                    sat_clr,
  output logic                    sat_sticky,
  output logic [CNT_W-1:0]        sat_count
);
  localparam int D = W_IN_MAX - W_OUT;
  localparam logic [7:0] WMAX = 8'(W_IN_MAX);
  if (W_OUT > W_IN_MAX || (IS_SIGNED && W_OUT < 2)) begin : g_bad_param
    $error("round_sat_stream: W_OUT must be <= W_IN_MAX and >= 2 when signed");
  end
  logic [7:0] sh;
  logic s1_v, s2_adv;
  logic [NCH*W_OUT-1:0] t_in, s1_t, r_out;
  logic [NCH-1:0] inc_in, s1_inc, sat_out;
  assign sh = (s_prec == 8'd0 || s_prec > WMAX) ? 8'd0 : WMAX - s_prec;
  assign s2_adv = !m_valid || m_ready;
  assign s_ready = rst_n && (!s1_v || s2_adv);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W_IN_MAX-1:0] a;
    assign a = s_data[c*W_IN_MAX +: W_IN_MAX] << sh;
    assign t_in[c*W_OUT +: W_OUT] = a[W_IN_MAX-1:D];
    if (D == 0) begin : g_pass
      assign inc_in[c] = 1'b0;
      assign r_out[c*W_OUT +: W_OUT] = s1_t[c*W_OUT +: W_OUT];
      assign sat_out[c] = 1'b0;
    end else begin : g_rnd
      localparam logic [D-1:0] H = D'(1) << (D-1);
      logic [D-1:0] f;
      logic gt, eq, neg;
      logic [W_OUT-1:0] st;
      logic [W_OUT:0] r;
      assign f = a[D-1:0];
      assign gt = f > H;
      assign eq = f == H;
      assign neg = IS_SIGNED && a[W_IN_MAX-1];
      assign inc_in[c] = s_mode == 2'd0 ? 1'b0 :
                         s_mode == 2'd1 ? (gt || eq) :
                         s_mode == 2'd2 ? (gt || (eq && a[D])) : (gt || (eq && !neg));
      assign st = s1_t[c*W_OUT +: W_OUT];
      assign r = {IS_SIGNED && st[W_OUT-1], st} + {{W_OUT{1'b0}}, s1_inc[c]};
      assign sat_out[c] = IS_SIGNED ? r[W_OUT] != r[W_OUT-1] : r[W_OUT];
      assign r_out[c*W_OUT +: W_OUT] = !sat_out[c] ? r[W_OUT-1:0] :
                                       IS_SIGNED ? {W_OUT{!r[W_OUT]}} ^ (W_OUT'(1) << (W_OUT-1)) : '1;
    end
  end
  // S1: capture the truncated aligned sample and its rounding increment
  always_ff @(posedge clk)
    if (!rst_n) s1_v <= 1'b0;
    else if (!s1_v || s2_adv) begin
      s1_v <= s_valid;
      if (s_valid) begin
        s1_t <= t_in;
        s1_inc <= inc_in;
      end
    end
  // S2: add increment, clamp, and hold the result while downstream stalls
  always_ff @(posedge clk)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_sat <= '0;
    end else if (s2_adv) begin
      m_valid <= s1_v;
      if (s1_v) begin
        m_data <= r_out;
        m_sat <= sat_out;
      end
    end
  // record saturated deliveries; a coincident clear wins over the event
  always_ff @(posedge clk)
    if (!rst_n || sat_clr) begin
      sat_sticky <= 1'b0;
      sat_count <= '0;
    end else if (m_valid && m_ready && |m_sat) begin
      sat_sticky <= 1'b1;
      if (!(&sat_count)) sat_count <= sat_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_round_sat_stream.sv
// tb_round_sat_stream: randomized self-checking bench for round_sat_stream against an arithmetic model
module tb_round_sat_stream;
  localparam int NBEAT = 1000;
  logic clk = 1'b0;
  logic rst_n, s_valid, s_ready, m_valid, m_ready, sat_clr, sat_sticky;
  logic [75:0] s_data;
  logic [7:0] s_prec;
  logic [1:0] s_mode;
  logic [63:0] m_data;
  logic [3:0] m_sat;
  logic [15:0] sat_count;
  int checks = 0;
  int failures = 0;
  round_sat_stream dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_prec(s_prec), .s_mode(s_mode), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sat(m_sat), .sat_clr(sat_clr), .sat_sticky(sat_sticky),
    .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [75:0] rep(input logic [18:0] x);
    return {4{x}};
  endfunction
  function automatic logic [63:0] rep16(input logic [15:0] y);
    return {4{y}};
  endfunction
  function automatic logic [18:0] rnd19();
    int k;
    k = $urandom_range(0, 3);
    return k == 2 ? 19'h3FFF8 | 19'($urandom_range(0, 7)) :
           k == 3 ? 19'h40000 | 19'($urandom_range(0, 7)) : 19'($urandom());
  endfunction
  function automatic void model(input logic [75:0] d, input logic [7:0] prec, input logic [1:0] mode,
                                output logic [63:0] od, output logic [3:0] os);
    int p;
    longint v, a, t, f, r;
    bit inc;
    p = (prec == 8'd0 || prec > 8'd19) ? 19 : int'(prec);
    od = '0;
    os = '0;
    for (int c = 0; c < 4; c++) begin
      v = longint'(d[c*19 +: 19]) & ((longint'(1) << p) - 1);
      if (v >= (longint'(1) << (p - 1))) v -= longint'(1) << p;
      a = v * (longint'(1) << (19 - p));
      f = a & 7;
      t = (a - f) / 8;
      inc = mode == 2'd0 ? 1'b0 : mode == 2'd1 ? f >= 4 :
            mode == 2'd2 ? (f > 4 || (f == 4 && (t & 1) != 0)) : (f > 4 || (f == 4 && a >= 0));
      r = t + (inc ? 1 : 0);
      if (r > 32767) begin r = 32767; os[c] = 1'b1; end
      else if (r < -32768) begin r = -32768; os[c] = 1'b1; end
      od[c*16 +: 16] = r[15:0];
    end
  endfunction
  task automatic send_beat(input logic [75:0] d, input logic [7:0] prec, input logic [1:0] mode, input bit clr,
                           output logic [63:0] od, output logic [3:0] os, output int lat);
    s_data = d;
    s_prec = prec;
    s_mode = mode;
    s_valid = 1'b1;
    m_ready = 1'b1;
    step();
    lat = 1;
    s_valid = 1'b0;
    s_prec = 8'($urandom());
    s_mode = 2'($urandom());
    s_data = 76'($urandom());
    while (!m_valid && lat < 10) begin
      step();
      lat++;
    end
    od = m_data;
    os = m_sat;
    sat_clr = clr;
    step();
    sat_clr = 1'b0;
  endtask
  task automatic run_dir(input string tag, input logic [75:0] d, input logic [7:0] prec, input logic [1:0] mode,
                         input logic [63:0] ed, input logic [3:0] es);
    logic [63:0] od;
    logic [3:0] os;
    int lat;
    send_beat(d, prec, mode, 1'b0, od, os, lat);
    chk({tag, "_data"}, od, ed);
    chk({tag, "_sat"}, os, es);
    chk({tag, "_lat"}, lat, 2);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [67:0] q[$];
    logic [67:0] e, held;
    logic [75:0] d;
    logic [63:0] md, od;
    logic [3:0] ms, os;
    bit acc, stall;
    int sent, cyc, lat;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_prec = '0;
    s_mode = '0;
    m_ready = 1'b0;
    sat_clr = 1'b0;
    repeat (3) step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_sticky", sat_sticky, 0);
    chk("rst_count", sat_count, 0);
    rst_n = 1'b1;
    step();
    chk("idle_s_ready", s_ready, 1);
    run_dir("half_even_2p5", rep(19'h00014), 8'd19, 2'd2, rep16(16'h0002), 4'h0);
    run_dir("half_even_3p5", rep(19'h0001C), 8'd19, 2'd2, rep16(16'h0004), 4'h0);
    run_dir("neg_m2", rep(19'h7FFEC), 8'd19, 2'd2, rep16(16'hFFFE), 4'h0);
    run_dir("neg_m3", rep(19'h7FFEC), 8'd19, 2'd3, rep16(16'hFFFD), 4'h0);
    run_dir("neg_m1", rep(19'h7FFEC), 8'd19, 2'd1, rep16(16'hFFFE), 4'h0);
    run_dir("neg_m0", rep(19'h7FFEC), 8'd19, 2'd0, rep16(16'hFFFD), 4'h0);
    chk("no_sat_count", sat_count, 0);
    run_dir("sat_max_a", rep(19'h3FFFC), 8'd19, 2'd2, rep16(16'h7FFF), 4'hF);
    run_dir("sat_max_b", rep(19'h3FFFF), 8'd19, 2'd2, rep16(16'h7FFF), 4'hF);
    chk("sticky_after2", sat_sticky, 1);
    chk("count_after2", sat_count, 2);
    run_dir("min_exact", rep(19'h40000), 8'd19, 2'd2, rep16(16'h8000), 4'h0);
    run_dir("prec16", rep(19'h08000), 8'd16, 2'd2, rep16(16'h8000), 4'h0);
    run_dir("prec0", rep(19'h00014), 8'd0, 2'd2, rep16(16'h0002), 4'h0);
    run_dir("prec_big", rep(19'h0001C), 8'd77, 2'd2, rep16(16'h0004), 4'h0);
    run_dir("mixed", {19'h3FFFF, 19'h40000, 19'h00014, 19'h3FFFC}, 8'd19, 2'd2,
            {16'h7FFF, 16'h8000, 16'h0002, 16'h7FFF}, 4'b1001);
    acc = 1'b0;
    stall = 1'b0;
    sent = 0;
    cyc = 0;
    held = '0;
    while ((sent < NBEAT || q.size() > 0) && cyc < 20000) begin
      if (!s_valid || acc) begin
        if (sent < NBEAT) begin
          for (int c = 0; c < 4; c++) d[c*19 +: 19] = rnd19();
          s_data = d;
          s_prec = 8'($urandom_range(0, 24));
          s_mode = 2'($urandom_range(0, 3));
          s_valid = 1'b1;
        end else s_valid = 1'b0;
      end
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stream_s_ready", s_ready, !(q.size() == 2 && !m_ready));
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", {m_sat, m_data}, held);
      end
      if (m_valid && m_ready) begin
        chk("stream_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("stream_beat", {m_sat, m_data}, e);
        end
      end
      stall = m_valid && !m_ready;
      held = {m_sat, m_data};
      acc = s_valid && s_ready;
      if (acc) begin
        model(s_data, s_prec, s_mode, md, ms);
        q.push_back({ms, md});
        sent++;
      end
      step();
      cyc++;
    end
    s_valid = 1'b0;
    chk("stream_drained", q.size(), 0);
    chk("stream_sent", sent, NBEAT);
    step();
    send_beat(rep(19'h3FFFF), 8'd19, 2'd2, 1'b1, od, os, lat);
    chk("clr_wins_count", sat_count, 0);
    chk("clr_wins_sticky", sat_sticky, 0);
    send_beat(rep(19'h3FFFF), 8'd19, 2'd2, 1'b0, od, os, lat);
    chk("post_clr_count", sat_count, 1);
    chk("post_clr_sticky", sat_sticky, 1);
    s_data = rep(19'h3FFFF);
    s_prec = 8'd19;
    s_mode = 2'd2;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    s_valid = 1'b0;
    repeat (3) step();
    chk("count_saturates", sat_count, 16'hFFFF);
    chk("count_sticky", sat_sticky, 1);
    s_valid = 1'b1;
    repeat (3) step();
    chk("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_sat", m_sat, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_count", sat_count, 0);
    rst_n = 1'b1;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_stale", m_valid, 0);
    end
    chk("post_rst_s_ready", s_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
